imem_boot_loader: RTL and testbench

//  Write side of the instruction-memory interface: receives a framed byte stream and writes 32-bit

---
 rtl/mips_boot_pkg.sv | 23 ++
 rtl/boot_word_packer.sv | 43 ++++
 rtl/imem_boot_loader.sv | 153 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_boot_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
package mips_boot_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned DEPTH_DEF = 256;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [ADDR_W-1:0] BASE_ADDR_DEF = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } boot_state_t;

endpackage

// File: rtl/boot_word_packer.sv
// Assembles four MSB-first bytes into a 32-bit word; flags the 4th byte combinationally.
module boot_word_packer
  import mips_boot_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              load,
  input  logic              clear,
  output logic [WORD_W-1:0] word_c,
  output logic              word_full_c
);

  logic [23:0] sh_q, sh_d;
  logic [1:0]  cnt_q, cnt_d;

  // Completed word includes the byte being accepted this cycle
  assign word_c      = {sh_q, byte_in};
  assign word_full_c = load && (cnt_q == 2'd3);

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (clear) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (load) begin
      sh_d  = {sh_q[15:0], byte_in};
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader writing instruction words; holds the core in reset until a valid image lands.
module imem_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter logic [BYTE_W-1:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  boot_state_t       state_q, state_d;
  logic [BYTE_W-1:0] cnt_hi_q, cnt_hi_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [BYTE_W-1:0] csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              rx_ready_q, rx_ready_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              cpu_hold_q, cpu_hold_d;

  logic              accept;
  logic              pack_load;
  logic              pack_clear;
  logic [WORD_W-1:0] pack_word_c;
  logic              pack_full_c;
  logic [CNT_W-1:0]  n_c;

  assign accept     = rx_valid && rx_ready_q;
  assign pack_load  = accept && (state_q == ST_PAYLOAD);
  assign pack_clear = (state_q != ST_PAYLOAD);
  assign n_c        = {cnt_hi_q, rx_data};

  boot_word_packer u_packer (
    .clock       (clock),
    .reset       (reset),
    .byte_in     (rx_data),
    .load        (pack_load),
    .clear       (pack_clear),
    .word_c      (pack_word_c),
    .word_full_c (pack_full_c)
  );

  always_comb begin
    state_d    = state_q;
    cnt_hi_d   = cnt_hi_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    // Address advances once the current write has been presented
    if (we_q) addr_d = addr_q + 32'd4;

    case (state_q)
      ST_IDLE: begin
        if (accept && (rx_data == SYNC_BYTE)) state_d = ST_CNT_HI;
      end
      ST_CNT_HI: begin
        if (accept) begin
          cnt_hi_d = rx_data;
          state_d  = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (accept) begin
          n_d        = n_c;
          word_cnt_d = '0;
          csum_d     = '0;
          if (32'(n_c) > DEPTH_WORDS) state_d = ST_ERROR;
          else if (n_c == '0)         state_d = ST_CSUM;
          else                        state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
          if (pack_full_c) begin
            we_d       = 1'b1;
            wdata_d    = pack_word_c;
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q == (n_q - 16'd1)) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase

    rx_ready_d = (state_d != ST_DONE) && (state_d != ST_ERROR);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERROR);
    cpu_hold_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_hi_q   <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
      csum_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      rx_ready_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_hi_q   <= cnt_hi_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      csum_q     <= csum_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rx_ready_q <= rx_ready_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: a frame-level model predicts writes and the final outcome.
module tb_imem_boot_loader;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0;
  localparam logic [7:0]  SYNC  = 8'hA5;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clock;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  imem_boot_loader dut (
    .clock      (clock),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next predicted write
  always @(negedge clock) begin
    if (!reset && imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", imem_addr, e.addr);
        chk("write_data", imem_wdata, e.data);
      end
    end
  end

  // Frame-level reference: outcome 0=incomplete, 1=done, 2=error; last_idx = last byte the loader takes
  task automatic model(input bytes_t f, output int outcome, output int last_idx);
    int i, n, p, ci;
    logic [7:0] cs;
    outcome  = 0;
    last_idx = f.size() - 1;
    i = -1;
    for (int j = 0; j < f.size(); j++) begin
      if (f[j] == SYNC) begin
        i = j;
        break;
      end
    end
    if (i < 0 || f.size() < i + 3) return;
    n = 32'({f[i+1], f[i+2]});
    if (n > DEPTH) begin
      outcome  = 2;
      last_idx = i + 2;
      return;
    end
    cs = 8'h00;
    for (int k = 0; k < n; k++) begin
      wr_t w;
      p = i + 3 + 4 * k;
      if (p + 3 >= f.size()) return;
      w.addr = BASE + 32'(4 * k);
      w.data = {f[p], f[p+1], f[p+2], f[p+3]};
      exp_q.push_back(w);
      cs = cs ^ f[p] ^ f[p+1] ^ f[p+2] ^ f[p+3];
    end
    ci = i + 3 + 4 * n;
    if (ci >= f.size()) return;
    outcome  = (f[ci] == cs) ? 1 : 2;
    last_idx = ci;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acc);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    acc = rx_ready;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    exp_q.delete();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", imem_addr, BASE);
    chk("rst_imem_wdata", imem_wdata, 32'h0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic run_frame(input string name, input bytes_t f, input int gmin, input int gmax);
    int   outcome, last_idx, g;
    logic acc;
    model(f, outcome, last_idx);
    for (int idx = 0; idx < f.size(); idx++) begin
      send_byte(f[idx], acc);
      chk({name, "_accept"}, 32'(acc), 32'(idx <= last_idx));
      g = gmin + int'($urandom_range(gmax - gmin));
      repeat (g) begin
        @(posedge clock);
        #1;
      end
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk({name, "_done"}, 32'(done), 32'(outcome == 1));
    chk({name, "_error"}, 32'(error), 32'(outcome == 2));
    chk({name, "_cpu_hold"}, 32'(cpu_hold), 32'(outcome != 1));
    chk({name, "_rx_ready"}, 32'(rx_ready), 32'(outcome == 0));
    chk({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    @(posedge clock);
    #1;
  endtask

  function automatic bytes_t xor_tail(input bytes_t f, input int start);
    bytes_t r;
    logic [7:0] cs;
    r  = f;
    cs = 8'h00;
    for (int i = start; i < f.size(); i++) cs = cs ^ f[i];
    r.push_back(cs);
    return r;
  endfunction

  initial begin
    bytes_t t1, f, pre;
    logic   acc;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b1;

    t1 = xor_tail('{8'hA5, 8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05,
                    8'h01, 8'h09, 8'h50, 8'h20}, 3);

    do_reset();
    run_frame("t1", t1, 0, 0);

    do_reset();
    f = '{8'hA5, 8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h58};
    run_frame("t1_csum58", f, 0, 0);

    do_reset();
    f = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run_frame("t2", f, 0, 0);

    do_reset();
    f = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    run_frame("t3", f, 0, 0);

    do_reset();
    f = '{8'hA5, 8'h01, 8'h01, 8'h11, 8'h22, 8'h33};
    run_frame("t4", f, 0, 0);

    do_reset();
    f = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("n256_partial", f, 0, 1);

    do_reset();
    f = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("t5", f, 0, 0);

    do_reset();
    run_frame("t5_stall", t1, 5, 5);

    // Mid-frame asynchronous reset after two payload bytes
    do_reset();
    pre = '{};
    for (int i = 0; i < 5; i++) pre.push_back(t1[i]);
    run_frame("t6_prefix", pre, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_rx_ready", 32'(rx_ready), 32'd1);
    chk("t6_async_addr", imem_addr, BASE);
    chk("t6_async_cpu_hold", 32'(cpu_hold), 32'd1);
    do_reset();
    run_frame("t6_replay", t1, 0, 0);

    // Randomized frames: junk prefix, random counts, occasional bad checksum / overflow
    for (int r = 0; r < 30; r++) begin
      int mode, n, junk, trail;
      do_reset();
      f = '{};
      junk = int'($urandom_range(2));
      for (int j = 0; j < junk; j++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        f.push_back(b);
      end
      mode = int'($urandom_range(7));
      n = (mode == 0) ? 257 + int'($urandom_range(2000)) : int'($urandom_range(5));
      f.push_back(SYNC);
      f.push_back(8'(n >> 8));
      f.push_back(8'(n));
      if (mode != 0) begin
        int start;
        start = f.size();
        for (int k = 0; k < 4 * n; k++) f.push_back(8'($urandom));
        f = xor_tail(f, start);
        if (mode == 1) f[f.size()-1] = f[f.size()-1] ^ 8'(1 + $urandom_range(254));
      end
      trail = int'($urandom_range(2));
      for (int j = 0; j < trail; j++) f.push_back(8'($urandom));
      run_frame("rand", f, 0, 3);
    end

    // Terminal state must refuse a byte even when valid stays high
    send_byte(8'hA5, acc);
    chk("terminal_refuse", 32'(acc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
